// File: rtl/dmem_responder.sv
// dmem_responder: 2^AW x DW data RAM behind the memory stage.
// Zero sweep after reset, pipeline port first, debug port second.
module dmem_responder #(
    parameter int AW = 8,
    parameter int DW = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_en,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_valid,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          busy
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_DACK
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_clr_ptr;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rsp_rdata;
    logic          r_rsp_valid;
    logic [DW-1:0] r_dbg_rdata;
    logic          r_dbg_ack;

    logic          w_clr;
    logic          w_pipe;
    logic          w_dbg;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;

    assign w_clr  = (r_state == S_INIT);
    assign w_pipe = !w_clr && req_en;
    // Debug only wins an idle RUN cycle; DACK never accepts.
    assign w_dbg  = (r_state == S_RUN) && !req_en && dbg_req;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_ptr;
        w_wdata = '0;
        if (!reset) begin
            unique case (1'b1)
                w_clr: begin
                    w_we = 1'b1;
                end
                w_pipe: begin
                    w_we    = req_we;
                    w_waddr = req_addr;
                    w_wdata = req_wdata;
                end
                w_dbg: begin
                    w_we    = dbg_we;
                    w_waddr = dbg_addr;
                    w_wdata = dbg_wdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR_ON_RESET ? S_INIT : S_RUN;
            r_clr_ptr   <= '0;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b0;
            r_dbg_rdata <= '0;
            r_dbg_ack   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_dbg_ack   <= 1'b0;
            if (w_pipe && !req_we) begin
                r_rsp_rdata <= r_mem[req_addr];
                r_rsp_valid <= 1'b1;
            end
            case (r_state)
                S_INIT: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == '1) r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_dbg) begin
                        if (!dbg_we) r_dbg_rdata <= r_mem[dbg_addr];
                        r_dbg_ack <= 1'b1;
                        r_state   <= S_DACK;
                    end
                end
                S_DACK: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_valid = r_rsp_valid;
    assign dbg_rdata = r_dbg_rdata;
    assign dbg_ack   = r_dbg_ack;
    assign busy      = w_clr;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plan plus random traffic,
// all outputs compared every cycle against a behavioural model.
module tb_dmem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_en, req_we;
    logic [7:0] req_addr, req_wdata;
    logic [7:0] rsp_rdata;
    logic       rsp_valid;
    logic       dbg_req, dbg_we;
    logic [7:0] dbg_addr, dbg_wdata;
    logic [7:0] dbg_rdata;
    logic       dbg_ack;
    logic       busy;

    always #5 clk = ~clk;

    dmem_responder #(
        .AW(8),
        .DW(8),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_en   (req_en),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata),
        .rsp_valid(rsp_valid),
        .dbg_req  (dbg_req),
        .dbg_we   (dbg_we),
        .dbg_addr (dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata),
        .dbg_ack  (dbg_ack),
        .busy     (busy)
    );

    // Reference: contents, remaining sweep cycles, expected outputs.
    logic [7:0] m_mem [256];
    int         m_sweep;
    logic [7:0] m_rsp;
    logic       m_rv;
    logic [7:0] m_dr;
    logic       m_ack;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic acked_last;
        acked_last = m_ack;
        m_rv  = 1'b0;
        m_ack = 1'b0;
        if (reset) begin
            m_sweep = 256;
            m_rsp   = 8'h00;
            m_dr    = 8'h00;
        end else if (m_sweep > 0) begin
            m_sweep--;
            if (m_sweep == 0)
                for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        end else if (req_en) begin
            if (req_we) begin
                m_mem[req_addr] = req_wdata;
            end else begin
                m_rsp = m_mem[req_addr];
                m_rv  = 1'b1;
            end
        end else if (dbg_req && !acked_last) begin
            if (dbg_we) m_mem[dbg_addr] = dbg_wdata;
            else m_dr = m_mem[dbg_addr];
            m_ack = 1'b1;
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic we,
                       input logic [7:0] a, input logic [7:0] wd,
                       input logic dr, input logic dwe,
                       input logic [7:0] da, input logic [7:0] dwd);
        reset     = rst;
        req_en    = en;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        dbg_req   = dr;
        dbg_we    = dwe;
        dbg_addr  = da;
        dbg_wdata = dwd;
        @(posedge clk);
        model_edge();
        #1;
        chk("busy", 32'(busy), 32'(m_sweep > 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp));
        chk("dbg_ack", 32'(dbg_ack), 32'(m_ack));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(m_dr));
    endtask

    task automatic idle();
        cyc(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        cyc(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    endtask

    // Counts busy samples from the reset edge on; sweep must be 256.
    task automatic sweep_len(input string tag, input bit poke);
        int n;
        n = 0;
        while (busy && n < 300) begin
            n++;
            if (poke && n == 5)
                cyc(0, 1, 1, 8'h10, 8'hAA, 1, 1, 8'h10, 8'hBB);
            else
                cyc(0, 1'($urandom), 1'($urandom), 8'($urandom),
                    8'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom), 8'($urandom));
        end
        chk(tag, 32'(n), 32'd256);
    endtask

    initial begin
        int lat;
        logic [3:0] pat;
        m_sweep = 0;
        m_rsp   = 8'h00;
        m_rv    = 1'b0;
        m_dr    = 8'h00;
        m_ack   = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

        do_reset();
        chk("rst_busy", 32'(busy), 32'd1);
        sweep_len("sweep_len", 1'b1);

        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00);
        chk("clr_00", 32'(dbg_rdata), 32'h00);
        idle();
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h7F, 8'h00);
        idle();
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'hFF, 8'h00);
        chk("clr_ff_ack", 32'(dbg_ack), 32'd1);
        idle();

        cyc(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("busy_write_dropped", 32'(rsp_rdata), 32'h00);

        cyc(0, 1, 1, 8'h22, 8'h3C, 0, 0, 8'h00, 8'h00);
        chk("wr_no_valid", 32'(rsp_valid), 32'd0);
        cyc(0, 1, 0, 8'h22, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("rd_22", 32'(rsp_rdata), 32'h3C);
        cyc(0, 1, 0, 8'h23, 8'h00, 0, 0, 8'h00, 8'h00);
        chk("rd_23_valid", 32'(rsp_valid), 32'd1);
        idle();

        lat = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 8'($urandom), 8'h00, 1, 1, 8'h40, 8'h55);
            lat++;
            chk("stall_no_ack", 32'(dbg_ack), 32'd0);
        end
        while (!dbg_ack && lat < 20) begin
            cyc(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'h55);
            lat++;
        end
        chk("arb_latency", 32'(lat), 32'd4);
        cyc(0, 1, 0, 8'h40, 8'h00, 0, 0, 8'h00, 8'h00);
        idle();
        chk("rd_40", 32'(rsp_rdata), 32'h55);

        pat = '0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00);
            pat = {pat[2:0], dbg_ack};
            if (dbg_ack) chk("dbg_rd_40", 32'(dbg_rdata), 32'h55);
        end
        chk("ack_pattern", 32'(pat), 32'b1010);
        idle();

        do_reset();
        for (int i = 0; i < 100; i++) idle();
        chk("mid_sweep_busy", 32'(busy), 32'd1);
        do_reset();
        sweep_len("sweep_restart", 1'b0);

        cyc(0, 1, 0, 8'h22, 8'h00, 1, 0, 8'h22, 8'h00);
        cyc(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h22, 8'h00);
        chk("pre_rst_ack", 32'(dbg_ack), 32'd1);
        cyc(1, 0, 0, 8'h00, 8'h00, 1, 0, 8'h22, 8'h00);
        chk("rst_ack_drop", 32'(dbg_ack), 32'd0);
        chk("rst_rsp", 32'(rsp_rdata), 32'h00);
        chk("rst_dbg_rdata", 32'(dbg_rdata), 32'h00);
        sweep_len("sweep_after_dack", 1'b0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 2) == 0),
                1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                ($urandom_range(0, 1) == 0), 1'($urandom),
                8'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

endmodule
